muldiv_sched: RTL and testbench
===============================

# muldiv_sched

Sequencing and arbitration controller for the single shared multiply/divide unit (MDU) in the dual-issue execute stage. Both issue lanes can request HI/LO arithmetic; the block grants the MDU to one lane at a time (lane 1 first, as the older instruction), issues a one-cycle start, counts the fixed unit latency, and captures HI/LO per lane. It then reports per-lane completion and a stage-level finish flag, which the execute stage ANDs into `finishE`.

## Interface
- `MUL_CYCLES`, default 2: cycles from `mdu_start` to valid `mdu_hi`/`mdu_lo` for MULT/MULTU; must be ≥1.
- `DIV_CYCLES`, default 32: same latency, for DIV/DIVU; must be ≥1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `flush`  in  1  pipeline flush of the execute stage; synchronous abort.
- `advance`  in  1  execute stage hands its bundle onward this cycle (`~stallE & finishE`).
- `req`  in  2  per-lane MDU request; held stable while the stage is stalled.
- `op1`, `op0`  in  2 each  per-lane operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `srca1`, `srcb1`, `srca0`, `srcb0`  in  32 each  per-lane operands.
- `mdu_start`  out  1  one-cycle start pulse to the MDU.
- `mdu_op`  out  2  operation for the MDU; valid while `mdu_start` is high.
- `mdu_srca`, `mdu_srcb`  out  32 each  operands for the MDU; valid while `mdu_start` is high.
- `mdu_abort`  out  1  kills the in-flight MDU operation.
- `mdu_hi`, `mdu_lo`  in  32 each  MDU result; valid in the completion cycle.
- `hi1`, `lo1`, `hi0`, `lo0`  out  32 each  captured per-lane results.
- `done`  out  2  per-lane result captured and valid.
- `finish`  out  1  every requesting lane is done.
- `busy`  out  1  the MDU is owned by this block.

## Operation
- States:
  - IDLE: no operation in progress.
  - START: the MDU is granted to lane `g`, and `mdu_start` is high.
  - WAIT: the cycle counter is running.
  - HOLD: all requesting lanes are done, waiting for `advance`.
- IDLE behaviour:
  - If `req[1] & ~done[1]`, set g=1 and go to START.
  - Otherwise, if `req[0] & ~done[0]`, set g=0 and go to START.
  - Otherwise stay in IDLE.
- START behaviour:
  - `mdu_op`, `mdu_srca` and `mdu_srcb` are combinationally muxed from lane `g`.
  - Latency `L` is latched: `op[1]`=1 gives DIV_CYCLES, otherwise MUL_CYCLES.
  - The counter is loaded to 1, and the state goes to WAIT.
- WAIT behaviour:
  - The counter increments each cycle.
  - In the cycle where counter == L, capture `mdu_hi`/`mdu_lo` into `hi_g`/`lo_g` and set `done[g]`.
  - Next state:
    - START with g=0 if `g`=1 and `req[0] & ~done[0]`.
    - Otherwise HOLD.
- Counter is `$clog2(max(MUL,DIV)+1)` bits wide and never wraps (L ≤ max).
- HOLD: on `advance`, clear `done` and go to IDLE. `hi*`/`lo*` keep their last values.
- `finish` = (~req[1] | done[1]) & (~req[0] | done[0]). It is combinational and is 1 when nothing is requested.
- `busy` = state ∈ {START, WAIT}.
- `flush` has highest priority in any state. It causes:
  - next state IDLE, `done` cleared, counter cleared;
  - `mdu_abort` asserted for the flush cycle whenever `busy`;
  - `mdu_start` forced low in the flush cycle.
- `advance` in START/WAIT is illegal and is ignored; the bench asserts that it never happens.
- `advance` in IDLE clears `done`. This covers lanes without requests.
- `req` is not re-examined after START. A dropped request still completes, and its result is captured.

## Timing
- Reset values: state IDLE. `mdu_start`, `mdu_abort`, `busy`, `done`, `hi*`, `lo*` and the counter are 0. `mdu_op`/`mdu_src*` are 0.
- The request is sampled in IDLE at edge 0. `mdu_start` is high in cycle 1. The result is valid in cycle 1+L, and `done` is high from cycle 2+L.
- For two requests, lane 0 START immediately follows lane 1 capture, with no idle gap. Lane 0 is done at cycle 3+L1+L0.
- The MDU's own HI/LO registers are not written by this block. The commit path uses `hi*`/`lo*`.

## Test plan
- Reset, then `req`=00 → `finish`=1, `busy`=0, `mdu_start` never asserted; `advance` keeps IDLE.
- Lane 0 MULTU with 0xFFFF_FFFF×2, MUL_CYCLES=2, req from cycle 0 → `mdu_start` in cycle 1 only, `done`=01 in cycle 4, `hi0`=0x1, `lo0`=0xFFFF_FFFE, `finish`=1 in cycle 4; `advance` → `done`=00.
- Both lanes in cycle 0: lane 1 DIV 100/7 (DIV_CYCLES=32), lane 0 MULT −3×5 → lane 1 start in cycle 1 and done in cycle 34 (hi1=2, lo1=14); lane 0 start in cycle 34 and done in cycle 37 (hi0=0xFFFF_FFFF, lo0=0xFFFF_FFF1); `finish` low until cycle 37.
- Flush in cycle 10 of a lane 1 DIV → `mdu_abort`=1 in cycle 10, IDLE in cycle 11, `done`=00, `hi1`/`lo1` unchanged. A new request then restarts cleanly with L counted from its own START.
- `resetn` asserted mid-WAIT → all outputs 0 asynchronously, with no capture when the stale MDU completes.
- Back-to-back bundles: `advance` in HOLD plus a new `req[0]` next cycle → new START one cycle after IDLE with fresh operands, and no stale `done`.

Source files
------------

// File: rtl/muldiv_sched.sv
// Arbitration and sequencing for the shared multiply/divide unit in the dual-issue execute stage.
// Lane 1 is served first; results are captured per lane and held until the bundle advances.
module muldiv_sched #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        advance,
  input  logic [1:0]  req,
  input  logic [1:0]  op1,
  input  logic [1:0]  op0,
  input  logic [31:0] srca1,
  input  logic [31:0] srcb1,
  input  logic [31:0] srca0,
  input  logic [31:0] srcb0,
  output logic        mdu_start,
  output logic [1:0]  mdu_op,
  output logic [31:0] mdu_srca,
  output logic [31:0] mdu_srcb,
  output logic        mdu_abort,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo,
  output logic [31:0] hi1,
  output logic [31:0] lo1,
  output logic [31:0] hi0,
  output logic [31:0] lo0,
  output logic [1:0]  done,
  output logic        finish,
  output logic        busy
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MulLat = CntW'(MUL_CYCLES);
  localparam logic [CntW-1:0] DivLat = CntW'(DIV_CYCLES);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic              g_q, g_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   lat_q, lat_d;
  logic [1:0]        done_q, done_d;
  logic [31:0]       hi1_q, hi1_d, lo1_q, lo1_d, hi0_q, hi0_d, lo0_q, lo0_d;

  logic [1:0]        op_g;
  logic [31:0]       srca_g, srcb_g;

  always_comb begin
    op_g   = g_q ? op1   : op0;
    srca_g = g_q ? srca1 : srca0;
    srcb_g = g_q ? srcb1 : srcb0;
  end

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    done_d    = done_q;
    hi1_d     = hi1_q;
    lo1_d     = lo1_q;
    hi0_d     = hi0_q;
    lo0_d     = lo0_q;
    mdu_start = 1'b0;
    mdu_op    = 2'b00;
    mdu_srca  = 32'h0;
    mdu_srcb  = 32'h0;

    case (state_q)
      StIdle: begin
        // Clearing here covers bundles that never requested the MDU
        if (advance) done_d = 2'b00;
        if (req[1] & ~done_q[1]) begin
          g_d     = 1'b1;
          state_d = StStart;
        end else if (req[0] & ~done_q[0]) begin
          g_d     = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        mdu_start = 1'b1;
        mdu_op    = op_g;
        mdu_srca  = srca_g;
        mdu_srcb  = srcb_g;
        lat_d     = op_g[1] ? DivLat : MulLat;
        cnt_d     = CntW'(1);
        state_d   = StWait;
      end
      StWait: begin
        if (cnt_q == lat_q) begin
          if (g_q) begin
            hi1_d     = mdu_hi;
            lo1_d     = mdu_lo;
            done_d[1] = 1'b1;
          end else begin
            hi0_d     = mdu_hi;
            lo0_d     = mdu_lo;
            done_d[0] = 1'b1;
          end
          // Lane 0 starts straight after lane 1 completes, no idle gap
          if (g_q & req[0] & ~done_q[0]) begin
            g_d     = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StHold;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (advance) begin
          done_d  = 2'b00;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d   = StIdle;
      done_d    = 2'b00;
      cnt_d     = '0;
      hi1_d     = hi1_q;
      lo1_d     = lo1_q;
      hi0_d     = hi0_q;
      lo0_d     = lo0_q;
      mdu_start = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      g_q     <= 1'b0;
      cnt_q   <= '0;
      lat_q   <= '0;
      done_q  <= 2'b00;
      hi1_q   <= 32'h0;
      lo1_q   <= 32'h0;
      hi0_q   <= 32'h0;
      lo0_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      done_q  <= done_d;
      hi1_q   <= hi1_d;
      lo1_q   <= lo1_d;
      hi0_q   <= hi0_d;
      lo0_q   <= lo0_d;
    end
  end

  assign busy      = (state_q == StStart) || (state_q == StWait);
  assign mdu_abort = flush & busy;
  assign finish    = (~req[1] | done_q[1]) & (~req[0] | done_q[0]);
  assign done      = done_q;
  assign hi1       = hi1_q;
  assign lo1       = lo1_q;
  assign hi0       = hi0_q;
  assign lo0       = lo0_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: behavioural MDU with exact latency, result scoreboard, directed phases.
module tb_muldiv_sched;

  localparam int unsigned MulC = 2;
  localparam int unsigned DivC = 32;

  logic        clk = 1'b0;
  logic        resetn, flush, advance;
  logic [1:0]  req, op1, op0;
  logic [31:0] srca1, srcb1, srca0, srcb0;
  logic        mdu_start, mdu_abort;
  logic [1:0]  mdu_op;
  logic [31:0] mdu_srca, mdu_srcb, mdu_hi, mdu_lo;
  logic [31:0] hi1, lo1, hi0, lo0;
  logic [1:0]  done;
  logic        finish, busy;

  always #5 clk = ~clk;

  muldiv_sched #(
    .MUL_CYCLES(MulC),
    .DIV_CYCLES(DivC)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .advance   (advance),
    .req       (req),
    .op1       (op1),
    .op0       (op0),
    .srca1     (srca1),
    .srcb1     (srcb1),
    .srca0     (srca0),
    .srcb0     (srcb0),
    .mdu_start (mdu_start),
    .mdu_op    (mdu_op),
    .mdu_srca  (mdu_srca),
    .mdu_srcb  (mdu_srcb),
    .mdu_abort (mdu_abort),
    .mdu_hi    (mdu_hi),
    .mdu_lo    (mdu_lo),
    .hi1       (hi1),
    .lo1       (lo1),
    .hi0       (hi0),
    .lo0       (lo0),
    .done      (done),
    .finish    (finish),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural MDU: result is only valid in the exact completion cycle
  function automatic logic [63:0] calc(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    longint sa, sb;
    int     q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    calc = 64'h0;
    case (op)
      2'b00: calc = sa * sb;
      2'b01: calc = {32'h0, a} * {32'h0, b};
      2'b10: begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        calc = {r, q};
      end
      default: calc = {a % b, a / b};
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] op);
    return op[1] ? int'(DivC) : int'(MulC);
  endfunction

  logic [63:0] m_res  = 64'h0;
  logic [1:0]  m_op   = 2'b00;
  int          m_k    = 0;
  logic        m_live = 1'b0;

  always @(posedge clk) begin
    if (mdu_abort) m_live <= 1'b0;
    if (mdu_start) begin
      m_res  <= calc(mdu_op, mdu_srca, mdu_srcb);
      m_op   <= mdu_op;
      m_k    <= 1;
      m_live <= 1'b1;
    end else begin
      m_k <= m_k + 1;
    end
  end

  assign mdu_hi = (m_live && m_k == lat_of(m_op)) ? m_res[63:32] : 32'hDEAD_BEEF;
  assign mdu_lo = (m_live && m_k == lat_of(m_op)) ? m_res[31:0]  : 32'h0BAD_F00D;

  // Scoreboard of captured results, in completion order
  typedef struct packed {
    logic        lane;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  logic [1:0] done_prev = 2'b00;

  task automatic push(input logic lane, input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.lane = lane;
    e.hi   = hi;
    e.lo   = lo;
    sb_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    for (int l = 1; l >= 0; l--) begin
      if (done[l] && !done_prev[l]) begin
        check_eq("sb_avail", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          sb_e = sb_q.pop_front();
          check_eq("sb_lane", l, sb_e.lane);
          check_eq("sb_hi", (l == 1) ? hi1 : hi0, sb_e.hi);
          check_eq("sb_lo", (l == 1) ? lo1 : lo0, sb_e.lo);
        end
      end
    end
    done_prev = done;
  end

  int n_starts = 0;
  always @(negedge clk) begin
    if (mdu_start) n_starts++;
    if (resetn && advance) check_eq("adv_legal", busy, 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    flush = 0; advance = 0; req = 2'b00; op1 = 2'b00; op0 = 2'b00;
    srca1 = 0; srcb1 = 0; srca0 = 0; srcb0 = 0;
    resetn = 0;
    tick(2);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_start", mdu_start, 0);
    check_eq("rst_abort", mdu_abort, 0);
    check_eq("rst_op", mdu_op, 0);
    check_eq("rst_srca", mdu_srca, 0);
    check_eq("rst_res", {hi1, lo1} | {hi0, lo0}, 0);
    check_eq("rst_finish", finish, 1);
    resetn = 1;
    tick(4);

    // Nothing requested
    check_eq("idle_finish", finish, 1);
    check_eq("idle_busy", busy, 0);
    advance = 1;
    tick();
    advance = 0;
    tick();
    check_eq("idle_adv_busy", busy, 0);
    check_eq("idle_starts", n_starts, 0);

    // Lane 0 MULTU 0xFFFFFFFF x 2
    req = 2'b01; op0 = 2'b01; srca0 = 32'hFFFF_FFFF; srcb0 = 32'd2;
    push(1'b0, 32'h1, 32'hFFFF_FFFE);
    tick();
    check_eq("mu_start_c1", mdu_start, 1);
    check_eq("mu_op_c1", mdu_op, 2'b01);
    check_eq("mu_srca_c1", mdu_srca, 32'hFFFF_FFFF);
    check_eq("mu_srcb_c1", mdu_srcb, 32'd2);
    check_eq("mu_finish_c1", finish, 0);
    tick();
    check_eq("mu_start_c2", mdu_start, 0);
    tick();
    check_eq("mu_done_c3", done, 2'b00);
    tick();
    check_eq("mu_done_c4", done, 2'b01);
    check_eq("mu_finish_c4", finish, 1);
    check_eq("mu_busy_c4", busy, 0);
    advance = 1;
    tick();
    advance = 0; req = 2'b00;
    check_eq("mu_done_clr", done, 2'b00);

    // Both lanes: lane 1 DIV 100/7, lane 0 MULT -3 x 5
    req = 2'b11;
    op1 = 2'b10; srca1 = 32'd100; srcb1 = 32'd7;
    op0 = 2'b00; srca0 = 32'hFFFF_FFFD; srcb0 = 32'd5;
    push(1'b1, 32'd2, 32'd14);
    push(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    for (int c = 1; c <= 37; c++) begin
      tick();
      check_eq("dual_start", mdu_start, (c == 1) || (c == 34));
      check_eq("dual_finish", finish, c >= 37);
      check_eq("dual_done", done, {c >= 34, c >= 37});
      if (c == 1) check_eq("dual_op1", mdu_op, 2'b10);
      if (c == 34) begin
        check_eq("dual_op0", mdu_op, 2'b00);
        check_eq("dual_srca0", mdu_srca, 32'hFFFF_FFFD);
      end
    end
    advance = 1;
    tick();
    advance = 0; req = 2'b00;

    // Flush in cycle 10 of a lane 1 DIVU, then a fresh request
    req = 2'b10; op1 = 2'b11; srca1 = 32'd5000; srcb1 = 32'd3;
    tick(10);
    check_eq("fl_busy_c10", busy, 1);
    flush = 1;
    #1;
    check_eq("fl_abort", mdu_abort, 1);
    check_eq("fl_start", mdu_start, 0);
    tick();
    flush = 0;
    check_eq("fl_idle", busy, 0);
    check_eq("fl_done", done, 2'b00);
    check_eq("fl_hi1", hi1, 32'd2);
    check_eq("fl_lo1", lo1, 32'd14);
    srca1 = 32'd1000; srcb1 = 32'd10;
    push(1'b1, 32'd0, 32'd100);
    tick();
    check_eq("fl_restart", mdu_start, 1);
    check_eq("fl_restart_a", mdu_srca, 32'd1000);
    tick(32);
    check_eq("fl_done_early", done, 2'b00);
    tick();
    check_eq("fl_done_new", done, 2'b10);
    advance = 1;
    tick();
    advance = 0; req = 2'b00;

    // Asynchronous reset in the middle of a lane 0 DIV
    req = 2'b01; op0 = 2'b10; srca0 = 32'd77; srcb0 = 32'd5;
    tick(5);
    check_eq("rw_busy", busy, 1);
    #1;
    resetn = 0;
    #1;
    check_eq("rw_busy0", busy, 0);
    check_eq("rw_done0", done, 0);
    check_eq("rw_res0", {hi1, lo1} | {hi0, lo0}, 0);
    check_eq("rw_start0", mdu_start, 0);
    req = 2'b00;
    tick(2);
    resetn = 1;
    tick(40);
    check_eq("rw_no_capture", {hi0, lo0}, 0);
    check_eq("rw_done_late", done, 0);

    // Back-to-back bundles on lane 0
    req = 2'b01; op0 = 2'b01; srca0 = 32'd6; srcb0 = 32'd7;
    push(1'b0, 32'd0, 32'd42);
    tick(4);
    check_eq("bb_done1", done, 2'b01);
    advance = 1;
    tick();
    advance = 0;
    op0 = 2'b00; srca0 = 32'hFFFF_FFFF; srcb0 = 32'd9;
    push(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF7);
    check_eq("bb_done_clr", done, 2'b00);
    check_eq("bb_nostart", mdu_start, 0);
    tick();
    check_eq("bb_start", mdu_start, 1);
    check_eq("bb_srca", mdu_srca, 32'hFFFF_FFFF);
    check_eq("bb_srcb", mdu_srcb, 32'd9);
    tick(3);
    check_eq("bb_done2", done, 2'b01);
    advance = 1;
    tick();
    advance = 0; req = 2'b00;
    tick(2);

    check_eq("sb_drained", sb_q.size(), 0);
    check_eq("start_count", n_starts, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
